// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl -- stall/flush sequencing controller for the 5-stage CPU.
//
// It is the only source of the pipeline registers' stall and flush controls.
// It detects load-use hazards between the EX-stage load and the ID
// instruction. It opens a flush window after a taken branch. It freezes the
// whole pipe while data memory reports busy.
//
// Parameters
//   LOAD_STALL_CYCLES  stall cycles per load-use hazard (1..15)
//   BR_PENALTY         flush cycles per taken branch, resolve cycle included (1..15)
//   MEM_TIMEOUT        consecutive busy cycles tolerated before err_o (1..65535)
//
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   ifid_rs_i/rt_i     source fields of the ID instruction
//   ifid_uses_rt_i     ID instruction reads rt
//   idex_memread_i     EX instruction is a load
//   idex_rt_i          destination of the EX load
//   branch_taken_i     branch resolved taken in EX this cycle
//   dmem_busy_i        data memory not ready this cycle
//   pc_write_o         PC may update
//   ifid_hold_o        IF/ID keeps contents
//   ifid_flush_o       IF/ID loads zero
//   idex_bubble_o      ID/EX loads a NOP
//   exmem_hold_o       EX/MEM and later stages hold
//   state_o            RUN=0, LSTALL=1, FLUSH=2
//   err_o              sticky memory-timeout flag
//   stall_cnt_o        perf counter: cycles with pc_write_o=0
//   flush_cnt_o        perf counter: taken branches accepted
//
// Build option: define PIPE_CTRL_PERF_EN to build the performance counters.
// When it is not defined, both counter ports are tied to zero.

module pipe_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int BR_PENALTY        = 1,
  parameter int MEM_TIMEOUT       = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  ifid_rs_i,
  input  logic [4:0]  ifid_rt_i,
  input  logic        ifid_uses_rt_i,
  input  logic        idex_memread_i,
  input  logic [4:0]  idex_rt_i,
  input  logic        branch_taken_i,
  input  logic        dmem_busy_i,
  output logic        pc_write_o,
  output logic        ifid_hold_o,
  output logic        ifid_flush_o,
  output logic        idex_bubble_o,
  output logic        exmem_hold_o,
  output logic [1:0]  state_o,
  output logic        err_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LSTALL = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  // The window counters hold the cycles still to go after the current one.
  localparam logic [3:0]  LSTALL_INIT = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [3:0]  FLUSH_INIT  = 4'(BR_PENALTY - 1);
  localparam logic [15:0] TO_MAX      = 16'(MEM_TIMEOUT);

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic [15:0] r_to_cnt;
  logic [15:0] w_to_next;
  logic        r_err;

  logic w_lu;
  logic w_pc_write;
  logic w_ifid_hold;
  logic w_ifid_flush;
  logic w_idex_bubble;
  logic w_exmem_hold;
  logic w_br_acc;

  // Register 0 is hardwired, so a load to it never creates a hazard.
  assign w_lu = idex_memread_i && (idex_rt_i != 5'd0) &&
                ((idex_rt_i == ifid_rs_i) ||
                 (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));

  // Next-state and control decode: reset, then memory busy, then state action
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_pc_write    = 1'b1;
    w_ifid_hold   = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    w_exmem_hold  = 1'b0;
    w_br_acc      = 1'b0;

    if (rst_i) begin
      w_pc_write    = 1'b0;
      w_ifid_flush  = 1'b1;
      w_idex_bubble = 1'b1;
      w_state_next  = ST_RUN;
      w_cnt_next    = 4'd0;
    end else if (dmem_busy_i) begin
      // Whole-pipe freeze; the state and the window count stay put.
      w_pc_write   = 1'b0;
      w_ifid_hold  = 1'b1;
      w_exmem_hold = 1'b1;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          // A taken branch wins over load-use, because the ID instruction is discarded anyway.
          if (branch_taken_i) begin
            w_br_acc      = 1'b1;
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
            if (BR_PENALTY > 1) begin
              w_state_next = ST_FLUSH;
              w_cnt_next   = FLUSH_INIT;
            end
          end else if (w_lu) begin
            w_pc_write    = 1'b0;
            w_ifid_hold   = 1'b1;
            w_idex_bubble = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              w_state_next = ST_LSTALL;
              w_cnt_next   = LSTALL_INIT;
            end
          end
        end
        ST_LSTALL: begin
          w_pc_write    = 1'b0;
          w_ifid_hold   = 1'b1;
          w_idex_bubble = 1'b1;
          if (r_cnt <= 4'd1) begin
            w_state_next = ST_RUN;
            w_cnt_next   = 4'd0;
          end else begin
            w_cnt_next = r_cnt - 4'd1;
          end
        end
        ST_FLUSH: begin
          // The redirected fetch is still in flight in I-mem, so keep squashing.
          w_pc_write    = 1'b0;
          w_ifid_flush  = 1'b1;
          w_idex_bubble = 1'b1;
          if (r_cnt <= 4'd1) begin
            w_state_next = ST_RUN;
            w_cnt_next   = 4'd0;
          end else begin
            w_cnt_next = r_cnt - 4'd1;
          end
        end
        default: begin
          w_state_next = ST_RUN;
          w_cnt_next   = 4'd0;
        end
      endcase
    end
  end

  // The timeout count saturates. The error flag rises on the edge where the count reaches the limit.
  assign w_to_next = !dmem_busy_i        ? 16'd0    :
                     (r_to_cnt == TO_MAX) ? r_to_cnt : r_to_cnt + 16'd1;

  // State register boundary
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_RUN;
      r_cnt    <= 4'd0;
      r_to_cnt <= 16'd0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_to_cnt <= w_to_next;
      r_err    <= r_err | (w_to_next == TO_MAX);
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Performance counter boundary
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (!w_pc_write) r_stall_cnt <= sat_inc32(r_stall_cnt);
      if (w_br_acc)    r_flush_cnt <= sat_inc32(r_flush_cnt);
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  assign stall_cnt_o = 32'd0;
  assign flush_cnt_o = 32'd0;
`endif

  assign pc_write_o    = w_pc_write;
  assign ifid_hold_o   = w_ifid_hold;
  assign ifid_flush_o  = w_ifid_flush;
  assign idex_bubble_o = w_idex_bubble;
  assign exmem_hold_o  = w_exmem_hold;
  assign state_o       = r_state;
  assign err_o         = r_err;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs, rt, irt;
  logic        urt, mr, br, busy;

  // u_def: default parameters; u_cfg: LOAD_STALL_CYCLES=2, BR_PENALTY=3, MEM_TIMEOUT=3
  logic        d_pc, d_hold, d_flush, d_bub, d_exh, d_err;
  logic [1:0]  d_st;
  logic [31:0] d_scnt, d_fcnt;
  logic        c_pc, c_hold, c_flush, c_bub, c_exh, c_err;
  logic [1:0]  c_st;
  logic [31:0] c_scnt, c_fcnt;

  int errors = 0;
  int checks = 0;

`ifdef PIPE_CTRL_PERF_EN
  localparam logic [31:0] EXP_SCNT = 32'd2;
  localparam logic [31:0] EXP_FCNT = 32'd1;
`else
  localparam logic [31:0] EXP_SCNT = 32'd0;
  localparam logic [31:0] EXP_FCNT = 32'd0;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl u_def (
    .clk_i(clk), .rst_i(rst), .ifid_rs_i(rs), .ifid_rt_i(rt), .ifid_uses_rt_i(urt),
    .idex_memread_i(mr), .idex_rt_i(irt), .branch_taken_i(br), .dmem_busy_i(busy),
    .pc_write_o(d_pc), .ifid_hold_o(d_hold), .ifid_flush_o(d_flush),
    .idex_bubble_o(d_bub), .exmem_hold_o(d_exh), .state_o(d_st), .err_o(d_err),
    .stall_cnt_o(d_scnt), .flush_cnt_o(d_fcnt)
  );

  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(2), .BR_PENALTY(3), .MEM_TIMEOUT(3)) u_cfg (
    .clk_i(clk), .rst_i(rst), .ifid_rs_i(rs), .ifid_rt_i(rt), .ifid_uses_rt_i(urt),
    .idex_memread_i(mr), .idex_rt_i(irt), .branch_taken_i(br), .dmem_busy_i(busy),
    .pc_write_o(c_pc), .ifid_hold_o(c_hold), .ifid_flush_o(c_flush),
    .idex_bubble_o(c_bub), .exmem_hold_o(c_exh), .state_o(c_st), .err_o(c_err),
    .stall_cnt_o(c_scnt), .flush_cnt_o(c_fcnt)
  );

  // Apply one cycle of inputs away from the rising edge, then let outputs settle.
  task automatic drive(input logic a_mr, input logic [4:0] a_irt, input logic [4:0] a_rs,
                       input logic [4:0] a_rt, input logic a_urt, input logic a_br,
                       input logic a_busy);
    @(negedge clk);
    rst = 1'b0; mr = a_mr; irt = a_irt; rs = a_rs; rt = a_rt; urt = a_urt;
    br = a_br; busy = a_busy;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; mr = 0; irt = 0; rs = 0; rt = 0; urt = 0; br = 0; busy = 0;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if ({d_pc, d_flush, d_bub, d_hold, d_exh} !== 5'b01100) begin errors++;
      $display("FAIL reset_ctrl got %b exp 01100", {d_pc, d_flush, d_bub, d_hold, d_exh}); end
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (d_st !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", d_st); end
    checks++; if (d_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", d_err); end
    checks++; if (d_pc !== 1'b1) begin errors++; $display("FAIL reset_pc got %0b exp 1", d_pc); end
    checks++; if (d_scnt !== 32'd0 || d_fcnt !== 32'd0) begin errors++;
      $display("FAIL reset_perf got %0d/%0d exp 0/0", d_scnt, d_fcnt); end
  endtask

  task automatic test_load_use();
    apply_reset();
    drive(1, 5, 5, 0, 0, 0, 0);
    checks++; if ({d_pc, d_hold, d_bub, d_flush, d_exh} !== 5'b01100) begin errors++;
      $display("FAIL lu_rs_ctrl got %b exp 01100", {d_pc, d_hold, d_bub, d_flush, d_exh}); end
    drive(0, 5, 5, 0, 0, 0, 0);
    checks++; if (d_pc !== 1'b1 || d_st !== 2'd0) begin errors++;
      $display("FAIL lu_release got pc=%0b st=%0d exp pc=1 st=0", d_pc, d_st); end
    drive(1, 7, 3, 7, 1, 0, 0);
    checks++; if ({d_pc, d_hold, d_bub} !== 3'b011) begin errors++;
      $display("FAIL lu_rt_ctrl got %b exp 011", {d_pc, d_hold, d_bub}); end
  endtask

  task automatic test_no_hazard();
    apply_reset();
    drive(1, 0, 0, 0, 1, 0, 0);
    checks++; if (d_pc !== 1'b1 || d_hold !== 1'b0) begin errors++;
      $display("FAIL nohz_r0 got pc=%0b hold=%0b exp 1/0", d_pc, d_hold); end
    drive(1, 9, 3, 9, 0, 0, 0);
    checks++; if (d_pc !== 1'b1 || d_hold !== 1'b0) begin errors++;
      $display("FAIL nohz_rt_unused got pc=%0b hold=%0b exp 1/0", d_pc, d_hold); end
    drive(0, 4, 4, 4, 1, 0, 0);
    checks++; if (d_pc !== 1'b1 || d_bub !== 1'b0) begin errors++;
      $display("FAIL nohz_noload got pc=%0b bub=%0b exp 1/0", d_pc, d_bub); end
  endtask

  task automatic test_branch();
    logic [2:0] exp_pc, exp_fl;
    logic [5:0] exp_st;
    exp_pc = 3'b100;      // cycles 1..3, listed msb = cycle 3
    exp_fl = 3'b011;
    exp_st = 6'b00_10_10;
    apply_reset();
    drive(0, 0, 0, 0, 0, 1, 0);
    checks++; if ({c_pc, c_flush, c_bub, c_hold, c_st} !== 6'b111000) begin errors++;
      $display("FAIL br_resolve got %b exp 111000", {c_pc, c_flush, c_bub, c_hold, c_st}); end
    for (int k = 1; k <= 3; k++) begin
      // a load-use pattern during the first flush cycle must be ignored
      if (k == 1) drive(1, 6, 6, 0, 0, 1, 0);
      else        drive(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (c_pc !== exp_pc[k-1] || c_flush !== exp_fl[k-1] || c_st !== exp_st[2*(k-1) +: 2] || c_hold !== 1'b0) begin
        errors++;
        $display("FAIL br_window_c%0d got pc=%0b fl=%0b st=%0d hold=%0b exp pc=%0b fl=%0b st=%0d hold=0",
                 k, c_pc, c_flush, c_st, c_hold, exp_pc[k-1], exp_fl[k-1], exp_st[2*(k-1) +: 2]);
      end
    end
  endtask

  task automatic test_branch_vs_lu();
    apply_reset();
    drive(1, 5, 5, 0, 0, 1, 0);
    checks++; if ({d_pc, d_flush, d_bub, d_hold} !== 4'b1110) begin errors++;
      $display("FAIL br_wins got %b exp 1110", {d_pc, d_flush, d_bub, d_hold}); end
  endtask

  task automatic test_busy_lstall();
    apply_reset();
    drive(1, 8, 8, 0, 0, 0, 0);
    checks++; if (c_pc !== 1'b0 || c_hold !== 1'b1 || c_st !== 2'd0) begin errors++;
      $display("FAIL bl_enter got pc=%0b hold=%0b st=%0d exp 0/1/0", c_pc, c_hold, c_st); end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 0, 1, 1);
      checks++;
      if ({c_st, c_pc, c_hold, c_exh, c_flush, c_bub} !== 7'b01_01100) begin errors++;
        $display("FAIL bl_busy_c%0d got %b exp 0101100", k, {c_st, c_pc, c_hold, c_exh, c_flush, c_bub}); end
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if ({c_st, c_pc, c_hold, c_bub, c_exh} !== 6'b01_0110) begin errors++;
      $display("FAIL bl_last_stall got %b exp 010110", {c_st, c_pc, c_hold, c_bub, c_exh}); end
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (c_st !== 2'd0 || c_pc !== 1'b1) begin errors++;
      $display("FAIL bl_run got st=%0d pc=%0b exp 0/1", c_st, c_pc); end
  endtask

  task automatic test_timeout();
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 0, 0, 0, 1);
      checks++; if (c_err !== (k >= 3)) begin errors++;
        $display("FAIL to_busy_c%0d got err=%0b exp %0b", k, c_err, (k >= 3)); end
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (c_err !== 1'b1 || c_pc !== 1'b1) begin errors++;
      $display("FAIL to_sticky got err=%0b pc=%0b exp 1/1", c_err, c_pc); end
    checks++; if (d_err !== 1'b0) begin errors++; $display("FAIL to_default got err=%0b exp 0", d_err); end
    apply_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (c_err !== 1'b0) begin errors++; $display("FAIL to_clear got err=%0b exp 0", c_err); end
  endtask

  task automatic test_perf();
    apply_reset();
    drive(1, 5, 5, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 3, 1, 3, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (d_scnt !== EXP_SCNT) begin errors++;
      $display("FAIL perf_stall got %0d exp %0d", d_scnt, EXP_SCNT); end
    checks++; if (d_fcnt !== EXP_FCNT) begin errors++;
      $display("FAIL perf_flush got %0d exp %0d", d_fcnt, EXP_FCNT); end
  endtask

  initial begin
    rst = 1'b1; mr = 0; irt = 0; rs = 0; rt = 0; urt = 0; br = 0; busy = 0;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch();
    test_branch_vs_lu();
    test_busy_lstall();
    test_timeout();
    test_perf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
